// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per clock. frame_start and done mark the first and last bit.
// The ready signal reopens on the last bit, so frames can follow each other
// with no idle bit. All outputs are decoded from registered state only.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;

  logic             w_shift;
  logic             w_last;
  logic             w_accept;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shreg_adv;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_last     = w_shift && (r_cnt == LAST);
  // Ready in IDLE, or on the last bit so the next word follows gaplessly.
  assign load_ready = !w_shift || w_last;
  assign w_accept   = load_valid && load_ready;

  // The output end and shift direction depend on the bit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit   = r_shreg[WIDTH-1];
      assign w_shreg_adv = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit   = r_shreg[0];
      assign w_shreg_adv = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign sout        = w_shift && w_out_bit;
  assign sout_valid  = w_shift;
  assign frame_start = w_shift && (r_cnt == '0);
  assign done        = w_last;

  // Frame sequencing: load on accept, shift until the last bit, then
  // either reload for a back-to-back frame or return to IDLE.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg <= din;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!w_last) begin
            r_shreg <= w_shreg_adv;
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_accept) begin
            r_shreg <= din;
            r_cnt   <= '0;
          end else begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_shreg <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Instance A: WIDTH=4, MSB first. Instance B: WIDTH=8, LSB first, with an
// 8-bit serial-in loopback register.
module tb_piso_serializer;

  logic       clk;
  logic       clear;
  logic [3:0] din_a;
  logic       lv_a;
  logic       rdy_a, sout_a, sv_a, fs_a, done_a;
  logic [7:0] din_b;
  logic       lv_b;
  logic       rdy_b, sout_b, sv_b, fs_b, done_b;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .clear(clear), .din(din_a), .load_valid(lv_a),
    .load_ready(rdy_a), .sout(sout_a), .sout_valid(sv_a),
    .frame_start(fs_a), .done(done_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .clear(clear), .din(din_b), .load_valid(lv_b),
    .load_ready(rdy_b), .sout(sout_b), .sout_valid(sv_b),
    .frame_start(fs_b), .done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-bit tuples {sout, frame_start, done}.
  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  int         acc_a = 0;
  int         acc_b = 0;
  logic [7:0] rx_b;
  logic       rx_chk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback receiver for instance B: LSB arrives first, shift right.
  always @(posedge clk) begin
    if (sv_b) rx_b <= {sout_b, rx_b[7:1]};
  end

  // Scoreboard for instance A.
  always @(negedge clk) begin
    logic [2:0] e;
    logic       exp_rdy;
    if (!clear) begin
      check_val("rst_out_a", {28'd0, sv_a, sout_a, fs_a, done_a}, 32'd0);
      check_val("rst_rdy_a", {31'd0, rdy_a}, 32'd1);
      q_a.delete();
    end else begin
      exp_rdy = (q_a.size() <= 1);
      check_val("rdy_a", {31'd0, rdy_a}, {31'd0, exp_rdy});
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_val("bit_a", {28'd0, sv_a, sout_a, fs_a, done_a}, {28'd0, 1'b1, e});
      end else begin
        check_val("idle_a", {28'd0, sv_a, sout_a, fs_a, done_a}, 32'd0);
      end
      if (lv_a && exp_rdy) begin
        $display("A accept din=%b t=%0t", din_a, $time);
        for (int i = 0; i < 4; i++)
          q_a.push_back({din_a[3-i], i == 0, i == 3});
        acc_a++;
      end
    end
  end

  // Scoreboard for instance B, plus loopback word check after done.
  always @(negedge clk) begin
    logic [2:0] e;
    logic       exp_rdy;
    if (!clear) begin
      q_b.delete();
      rx_chk = 1'b0;
    end else begin
      if (rx_chk) begin
        check_val("loopback_b", {24'd0, rx_b}, 32'hA5);
        rx_chk = 1'b0;
      end
      exp_rdy = (q_b.size() <= 1);
      check_val("rdy_b", {31'd0, rdy_b}, {31'd0, exp_rdy});
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_val("bit_b", {28'd0, sv_b, sout_b, fs_b, done_b}, {28'd0, 1'b1, e});
        if (e[0]) rx_chk = 1'b1;
      end else begin
        check_val("idle_b", {31'd0, sv_b}, 32'd0);
      end
      if (lv_b && exp_rdy) begin
        $display("B accept din=%h t=%0t", din_b, $time);
        for (int i = 0; i < 8; i++)
          q_b.push_back({din_b[i], i == 0, i == 7});
        acc_b++;
      end
    end
  end

  // Present a word on A and hold it until the model sees it accepted.
  task automatic send_a(input logic [3:0] w);
    int start;
    start = acc_a;
    din_a = w;
    lv_a  = 1'b1;
    for (int n = 0; n < 50 && acc_a == start; n++) @(negedge clk);
    if (acc_a == start) check_val("timeout_a", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    lv_a = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clear = 1'b0;
    din_a = '0;
    lv_a  = 1'b0;
    din_b = '0;
    lv_b  = 1'b0;
    rx_b  = '0;
    rx_chk = 1'b0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      din_a = 4'($urandom);
      lv_a  = 1'($urandom);
      din_b = 8'($urandom);
      lv_b  = 1'($urandom);
    end
    lv_a = 1'b0;
    lv_b = 1'b0;
    clear = 1'b1;
    idle_cycles(10);

    // Single frame.
    send_a(4'b1011);
    idle_cycles(6);

    // Back-to-back frames.
    send_a(4'b1011);
    send_a(4'b0110);
    idle_cycles(6);

    // Stall: offered word ignored until the done cycle.
    send_a(4'b0000);
    din_a = 4'b1111;
    lv_a  = 1'b1;
    idle_cycles(2);
    send_a(4'b1001);
    idle_cycles(6);

    // Abort mid-frame.
    send_a(4'b1100);
    idle_cycles(1);
    clear = 1'b0;
    #1;
    check_val("abort_out_a", {28'd0, sv_a, sout_a, fs_a, done_a}, 32'd0);
    check_val("abort_rdy_a", {31'd0, rdy_a}, 32'd1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    idle_cycles(2);
    send_a(4'b0011);
    idle_cycles(6);
    check_val("drain_a", q_a.size(), 32'd0);

    // LSB-first on instance B with loopback.
    begin
      int start;
      start = acc_b;
      din_b = 8'hA5;
      lv_b  = 1'b1;
      for (int n = 0; n < 50 && acc_b == start; n++) @(negedge clk);
      if (acc_b == start) check_val("timeout_b", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      lv_b = 1'b0;
    end
    idle_cycles(12);
    check_val("drain_b", q_b.size(), 32'd0);
    check_val("accepts_b", acc_b, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
